// File: rtl/pio_pulse_pkg.sv
// Shared register map, bit positions and FSM encoding for the PIO pulse output block.
package pio_pulse_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLR       = 3'd2;
    localparam logic [2:0] ADDR_PULSE     = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;
    localparam logic [2:0] ADDR_CTRL      = 3'd6;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned STATUS_ERR_BIT  = 2;

    localparam int unsigned CTRL_IRQ_EN_BIT = 0;
    localparam int unsigned CTRL_ABORT_BIT  = 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PULSING = 1'b1
    } state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse duration counter: loads max(len,1), counts down, flags the final cycle.
module pio_pulse_timer #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done_strobe
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    // Next count: abort clears, load starts, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (abort) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (len == '0) ? LEN_W'(1) : len;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy        = (cnt_q != '0);
    assign done_strobe = (cnt_q == LEN_W'(1)) & ~abort;

endmodule

// File: rtl/pio_pulse_out.sv
// Avalon-MM PIO output with timed inversion pulses and a completion interrupt.
module pio_pulse_out
    import pio_pulse_pkg::*;
#(
    parameter int unsigned           WIDTH       = 8,
    parameter int unsigned           LEN_W       = 16,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             irq_en_q, irq_en_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;
    logic             irq_q, irq_d;

    logic             wr;
    logic [WIDTH-1:0] wd_w;
    logic             timer_load;
    logic             timer_abort;
    logic             timer_busy;
    logic             timer_done;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_w      = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    pio_pulse_timer #(
        .LEN_W (LEN_W)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (timer_load),
        .len         (len_q),
        .abort       (timer_abort),
        .busy        (timer_busy),
        .done_strobe (timer_done)
    );

    // Register writes, pulse FSM transitions and registered output values.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mask_d      = mask_q;
        len_d       = len_q;
        done_d      = done_q;
        err_d       = err_q;
        irq_en_d    = irq_en_q;
        timer_load  = 1'b0;
        timer_abort = 1'b0;

        if (wr) begin
            case (address)
                ADDR_DATA:      data_d = wd_w;
                ADDR_SET:       data_d = data_q | wd_w;
                ADDR_CLR:       data_d = data_q & ~wd_w;
                ADDR_PULSE_LEN: len_d  = writedata[LEN_W-1:0];
                ADDR_STATUS: begin
                    if (writedata[STATUS_DONE_BIT]) done_d = 1'b0;
                    if (writedata[STATUS_ERR_BIT])  err_d  = 1'b0;
                end
                ADDR_CTRL:      irq_en_d = writedata[CTRL_IRQ_EN_BIT];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (wr && address == ADDR_PULSE && wd_w != '0) begin
                    mask_d     = wd_w;
                    timer_load = 1'b1;
                    state_d    = ST_PULSING;
                end
            end
            ST_PULSING: begin
                if (wr && address == ADDR_PULSE) begin
                    err_d = 1'b1;
                end
                // Abort beats a coincident terminal count: no completion is reported.
                if (wr && address == ADDR_CTRL && writedata[CTRL_ABORT_BIT]) begin
                    timer_abort = 1'b1;
                    state_d     = ST_IDLE;
                    mask_d      = '0;
                end else if (timer_done) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_port_d = data_d ^ mask_d;
        irq_d      = done_d & irq_en_d;
    end

    // State and register bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            len_q      <= LEN_W'(1);
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            out_port_q <= RESET_VALUE;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            len_q      <= len_d;
            done_q     <= done_d;
            err_q      <= err_d;
            irq_en_q   <= irq_en_d;
            out_port_q <= out_port_d;
            irq_q      <= irq_d;
        end
    end

    // Zero-latency read mux; unused and write-only locations read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata = 32'(data_q);
            ADDR_PULSE:     readdata = 32'(mask_q);
            ADDR_PULSE_LEN: readdata = 32'(len_q);
            ADDR_STATUS: begin
                readdata[STATUS_BUSY_BIT] = timer_busy;
                readdata[STATUS_DONE_BIT] = done_q;
                readdata[STATUS_ERR_BIT]  = err_q;
            end
            ADDR_CTRL:      readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            default: ;
        endcase
    end

    assign out_port = out_port_q;
    assign irq      = irq_q;

endmodule
